aes_sub_bytes: RTL and testbench



---
 rtl/aes_sub_bytes.sv | 60 ++++++
 tb/tb_aes_sub_bytes.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes.sv
// Registered AES-128 SubBytes stage: the FIPS-197 forward S-box is applied to each
// of the 16 state bytes, and the result is registered with one cycle of latency.

module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Forward S-box. Row n holds the outputs for the inputs n0..nf.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

module aes_sub_bytes (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic [127:0] Data_in,
    output logic [127:0] Data_out
);

    logic [127:0] sub_state;

    // Each byte lane stays in its own position, and no lane depends on another.
    for (genvar i = 0; i < 16; i++) begin : g_lane
        aes_sbox u_sbox (
            .din  (Data_in[8*i +: 8]),
            .dout (sub_state[8*i +: 8])
        );
    end

    // NOTE: The async clear is placed in the sensitivity list so the output drops as
    // soon as RST_n falls. The register loads with <= on every edge because there is no enable.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Data_out <= '0;
        end else begin
            Data_out <= sub_state;
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Self-checking bench for aes_sub_bytes. The expected S-box is derived here from
// GF(2^8) inversion followed by the affine transform.

module tb_aes_sub_bytes;

    logic         CLK;
    logic         RST_n;
    logic [127:0] Data_in;
    logic [127:0] Data_out;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] ref_sbox [256];

    aes_sub_bytes dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .Data_in  (Data_in),
        .Data_out (Data_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        if (v != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] state_model(input logic [127:0] s);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = ref_sbox[s[8*b +: 8]];
        return r;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [6];

        for (int v = 0; v < 256; v++) ref_sbox[v] = sbox_model(8'(v));

        vecs[0] = '{"zero",     128'h0,                                    {16{8'h63}}};
        vecs[1] = '{"ones_11",  {16{8'h11}},                               {16{8'h82}}};
        vecs[2] = '{"twos_22",  {16{8'h22}},                               {16{8'h93}}};
        vecs[3] = '{"byte_map", 128'h00112233445566778899aabbccddeeff,     128'h638293c31bfc33f5c4eeacea4bc12816};
        vecs[4] = '{"anchors",  128'h00_01_11_22_53_ff_00_01_11_22_53_ff_00_01_11_22,
                                128'h63_7c_82_93_ed_16_63_7c_82_93_ed_16_63_7c_82_93};
        vecs[5] = '{"all_ff",   {16{8'hff}},                               {16{8'h16}}};

        // Reset is held across several edges and must keep the output at zero.
        RST_n   = 1'b0;
        Data_in = {16{8'h11}};
        #1;
        check("reset_immediate", Data_out, 128'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check("reset_hold", Data_out, 128'h0);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
        check("release_before_edge", Data_out, 128'h0);
        @(posedge CLK); #1;
        check("release_first_edge", Data_out, {16{8'h82}});

        // The table vectors are driven at the negative edge and checked one rising edge later.
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            Data_in = vecs[i].din;
            @(posedge CLK); #1;
            check(vecs[i].name, Data_out, vecs[i].dout);
        end

        // Back-to-back inputs at edge-4 and edge+2 must produce no intermediate value.
        @(posedge CLK);
        #6 Data_in = {16{8'h11}};
        @(posedge CLK); #1;
        check("b2b_first", Data_out, {16{8'h82}});
        #1 Data_in = {16{8'h22}};
        #2;
        check("b2b_no_intermediate", Data_out, {16{8'h82}});
        @(posedge CLK); #1;
        check("b2b_second", Data_out, {16{8'h93}});

        // An async reset pulse between edges clears the output; the next edge reloads it.
        @(negedge CLK);
        Data_in = {16{8'h11}};
        @(posedge CLK); #1;
        check("pre_reset_value", Data_out, {16{8'h82}});
        #1 RST_n = 1'b0;
        #1;
        check("async_clear", Data_out, 128'h0);
        #1 RST_n = 1'b1;
        #1;
        check("clear_held_after_release", Data_out, 128'h0);
        Data_in = 128'h00112233445566778899aabbccddeeff;
        @(posedge CLK); #1;
        check("reload_after_reset", Data_out, 128'h638293c31bfc33f5c4eeacea4bc12816);

        // Every byte value is replicated across all lanes.
        for (int v = 0; v < 256; v++) begin
            @(negedge CLK);
            Data_in = {16{8'(v)}};
            @(posedge CLK); #1;
            check($sformatf("sweep_%02h", v), Data_out, {16{ref_sbox[v]}});
        end

        // Random states are applied one per cycle.
        for (int n = 0; n < 200; n++) begin
            logic [127:0] r;
            r = {$urandom, $urandom, $urandom, $urandom};
            @(negedge CLK);
            Data_in = r;
            @(posedge CLK); #1;
            check("random", Data_out, state_model(r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
